// File: rtl/seq_det_arbiter.sv
// seq_det_arbiter
// Arbitrates two word producers onto a single shared serial pattern detector.
// A granted word is loaded, the detector is cleared for one cycle, the word is
// shifted in MSB first, the sticky match flag is captured one cycle after the
// last bit, and the result is returned tagged with the requester id.
//
// Build option:
//   SEQ_ARB_RR_EN  defined   -> round-robin on contention (alternate winners)
//                  undefined -> fixed priority, requester 0 always wins
//
// State | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a request; ready offered to the selected requester
// CLR   | detector held in reset for one cycle, bit counter reloaded
// SHIFT | one word bit per cycle onto det_w, MSB first
// FLUSH | det_w idle; det_z now reflects the final bit and is captured
// RESP  | result presented until the consumer takes it

module seq_det_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             det_rst,
    output logic             det_w,
    input  logic             det_z,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic             rsp_match,
    input  logic             rsp_ready
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_FLUSH,
        S_RESP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic             grant0;
    logic             grant1;
    logic             idle_open;
    logic             accept;

`ifdef SEQ_ARB_RR_EN
    logic             last_grant;
`endif

    // Requester selection; ready is only offered in IDLE and never during reset
    always_comb begin
        grant1 = 1'b0;
`ifdef SEQ_ARB_RR_EN
        // On contention the requester that did not win last time goes next
        grant1 = req1_valid && (!req0_valid || !last_grant);
`else
        grant1 = req1_valid && !req0_valid;
`endif
        grant0     = req0_valid && !grant1;
        idle_open  = (state == S_IDLE) && !Rst;
        req0_ready = idle_open && grant0;
        req1_ready = idle_open && grant1;
        accept     = idle_open && (grant0 || grant1);
    end

    // Detector drive: reset follows the block reset as well as the CLR state
    always_comb begin
        det_rst = Rst || (state == S_CLR);
        det_w   = (state == S_SHIFT) && shreg[WIDTH-1];
    end

    // Sequencer FSM with registered response outputs
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= S_IDLE;
            shreg     <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_match <= 1'b0;
`ifdef SEQ_ARB_RR_EN
            // Makes requester 0 the winner of the first contention
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        shreg  <= grant1 ? req1_data : req0_data;
                        rsp_id <= grant1;
`ifdef SEQ_ARB_RR_EN
                        last_grant <= grant1;
`endif
                        state  <= S_CLR;
                    end
                end
                S_CLR: begin
                    cnt   <= '0;
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                    // Counter parks on the last index instead of wrapping
                    if (cnt == CNT_LAST) begin
                        state <= S_FLUSH;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_FLUSH: begin
                    rsp_match <= det_z;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Bench for seq_det_arbiter: drives directed jobs, models the serial detector,
// and compares every cycle against a job-timeline model of the arbiter.

module tb_seq_det_arbiter;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         req0_valid = 1'b0;
    logic [W-1:0] req0_data = '0;
    logic         req0_ready;
    logic         req1_valid = 1'b0;
    logic [W-1:0] req1_data = '0;
    logic         req1_ready;
    logic         det_rst;
    logic         det_w;
    logic         det_z;
    logic         rsp_valid;
    logic         rsp_id;
    logic         rsp_match;
    logic         rsp_ready = 1'b1;

    int n_chk  = 0;
    int n_fail = 0;

    seq_det_arbiter #(.WIDTH(W)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .det_rst    (det_rst),
        .det_w      (det_w),
        .det_z      (det_z),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_match  (rsp_match),
        .rsp_ready  (rsp_ready)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Serial detector: synchronous reset, sticky z, matches 1001 and 1111
    logic [3:0] det_hist;
    always @(posedge Clk) begin
        if (det_rst) begin
            det_hist <= 4'b0;
            det_z    <= 1'b0;
        end else begin
            det_hist <= {det_hist[2:0], det_w};
            if ({det_hist[2:0], det_w} == 4'b1001 || {det_hist[2:0], det_w} == 4'b1111)
                det_z <= 1'b1;
        end
    end

    // Whole-word answer: does 1001 or 1111 appear anywhere in the word, MSB first
    function automatic logic exp_match(input logic [W-1:0] word);
        logic m;
        m = 1'b0;
        for (int i = 0; i + 3 < W; i++) begin
            if (word[W-1-i -: 4] == 4'b1001 || word[W-1-i -: 4] == 4'b1111) m = 1'b1;
        end
        return m;
    endfunction

    // Job-timeline model: m_t counts cycles since the accept edge
    bit           m_busy = 1'b0;
    int           m_t = 0;
    bit           m_id = 1'b0;
    logic [W-1:0] m_word = '0;
`ifdef SEQ_ARB_RR_EN
    bit           m_last = 1'b1;
`endif

    function automatic bit pick1();
`ifdef SEQ_ARB_RR_EN
        if (req0_valid && req1_valid) return !m_last;
`endif
        return req1_valid && !req0_valid;
    endfunction

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m_busy = 1'b0;
            m_t    = 0;
`ifdef SEQ_ARB_RR_EN
            m_last = 1'b1;
`endif
        end else if (m_busy) begin
            if (m_t >= W + 3 && rsp_ready) m_busy = 1'b0;
            else m_t++;
        end else if (req0_valid || req1_valid) begin
            m_id   = pick1();
            m_word = m_id ? req1_data : req0_data;
`ifdef SEQ_ARB_RR_EN
            m_last = m_id;
`endif
            m_busy = 1'b1;
            m_t    = 1;
        end
    end

    logic e_g0, e_g1, e_rv, e_w;
    always @(negedge Clk) begin
        if (Rst) begin
            chk("rst_det_rst", det_rst, 1);
            chk("rst_req0_ready", req0_ready, 0);
            chk("rst_req1_ready", req1_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_match", rsp_match, 0);
            chk("rst_det_w", det_w, 0);
        end else begin
            e_g1 = !m_busy && pick1();
            e_g0 = !m_busy && req0_valid && !pick1();
            e_rv = m_busy && (m_t >= W + 3);
            e_w  = (m_busy && m_t >= 2 && m_t <= W + 1) ? m_word[W+1-m_t] : 1'b0;
            chk("mdl_req0_ready", req0_ready, e_g0);
            chk("mdl_req1_ready", req1_ready, e_g1);
            chk("mdl_det_rst", det_rst, m_busy && m_t == 1);
            chk("mdl_det_w", det_w, e_w);
            chk("mdl_rsp_valid", rsp_valid, e_rv);
            if (e_rv) begin
                chk("mdl_rsp_id", rsp_id, m_id);
                chk("mdl_rsp_match", rsp_match, exp_match(m_word));
            end
        end
    end

    task automatic send(input bit id, input logic [W-1:0] data);
        int k;
        if (id) begin req1_data = data; req1_valid = 1'b1; end
        else begin req0_data = data; req0_valid = 1'b1; end
        k = 0;
        @(negedge Clk);
        while (!(id ? req1_ready : req0_ready) && k < 100) begin
            k++;
            @(negedge Clk);
        end
        if (k >= 100) chk("send_timeout", 0, 1);
        @(posedge Clk);
        #1;
        if (id) req1_valid = 1'b0;
        else req0_valid = 1'b0;
    endtask

    // Full job with latency, clear pulse and bit-stream checks; rsp_ready must be high
    task automatic run_job(input string tag, input bit id, input logic [W-1:0] data, input bit m);
        int           nrst;
        bit           early;
        logic [W-1:0] wv;
        nrst = 0; early = 1'b0; wv = '0;
        send(id, data);
        for (int k = 1; k <= W + 3; k++) begin
            @(negedge Clk);
            if (det_rst) nrst++;
            if (k >= 2 && k <= W + 1) wv = {wv[W-2:0], det_w};
            if (k < W + 3 && rsp_valid) early = 1'b1;
        end
        chk({tag, "_early_rsp"}, early, 0);
        chk({tag, "_rsp_at_w3"}, rsp_valid, 1);
        chk({tag, "_rsp_id"}, rsp_id, id);
        chk({tag, "_rsp_match"}, rsp_match, m);
        chk({tag, "_det_rst_pulses"}, nrst, 1);
        chk({tag, "_det_w_seq"}, wv, data);
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_rsp(input string tag, input bit id, input bit m);
        int k;
        k = 0;
        @(negedge Clk);
        while (!rsp_valid && k < 100) begin
            k++;
            @(negedge Clk);
        end
        chk({tag, "_rsp_seen"}, rsp_valid, 1);
        chk({tag, "_rsp_id"}, rsp_id, id);
        chk({tag, "_rsp_match"}, rsp_match, m);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int nrv;
        // 1: reset with both requests pending
        req0_data = 8'h90; req0_valid = 1'b1;
        req1_data = 8'h55; req1_valid = 1'b1;
        rsp_ready = 1'b1;
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        chk("t1_first_grant_req0", req0_ready, 1);
        chk("t1_first_grant_req1", req1_ready, 0);
        @(posedge Clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp("t1", 0, 1);

        // literal pins on the match model
        chk("pin_match_90", exp_match(8'h90), 1);
        chk("pin_match_55", exp_match(8'h55), 0);
        chk("pin_match_00", exp_match(8'h00), 0);
        chk("pin_match_78", exp_match(8'h78), 1);

        // 2, 3: single jobs
        run_job("t2_req0_90", 0, 8'h90, 1);
        run_job("t3_req1_55", 1, 8'h55, 0);
        run_job("t3_req1_00", 1, 8'h00, 0);

        // 4: contention, both held
        req0_data = 8'h78; req1_data = 8'h55;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef SEQ_ARB_RR_EN
            wait_rsp($sformatf("t4_job%0d", i), i[0], !i[0]);
`else
            wait_rsp($sformatf("t4_job%0d", i), 1'b0, 1'b1);
`endif
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // 5: response backpressure with req1 waiting
        rsp_ready = 1'b0;
        send(0, 8'h90);
        req1_data = 8'h00; req1_valid = 1'b1;
        nrv = 0;
        @(negedge Clk);
        while (!rsp_valid && nrv < 100) begin
            nrv++;
            @(negedge Clk);
        end
        chk("t5_rsp_seen", rsp_valid, 1);
        repeat (5) begin
            @(negedge Clk);
            chk("t5_hold_valid", rsp_valid, 1);
            chk("t5_hold_id", rsp_id, 0);
            chk("t5_hold_match", rsp_match, 1);
            chk("t5_hold_req1_ready", req1_ready, 0);
        end
        @(posedge Clk);
        #1 rsp_ready = 1'b1;
        @(negedge Clk);
        chk("t5_last_valid", rsp_valid, 1);
        chk("t5_last_req1_ready", req1_ready, 0);
        @(negedge Clk);
        chk("t5_accept_next_cycle", req1_ready, 1);
        @(posedge Clk);
        #1 req1_valid = 1'b0;
        wait_rsp("t5_req1", 1, 0);

        // 6: reset during bit 4 of 0x90
        send(0, 8'h90);
        repeat (5) @(posedge Clk);
        #1 Rst = 1'b1;
        #1;
        chk("t6_imm_rsp_valid", rsp_valid, 0);
        chk("t6_imm_det_rst", det_rst, 1);
        chk("t6_imm_det_w", det_w, 0);
        chk("t6_imm_req0_ready", req0_ready, 0);
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        nrv = 0;
        repeat (W + 6) begin
            @(negedge Clk);
            if (rsp_valid) nrv++;
        end
        chk("t6_no_response", nrv, 0);
        run_job("t6_resubmit", 0, 8'h90, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "timeout");
    end

endmodule
